// File: rtl/ieee754_divider.sv
// Sequential IEEE-754 single-precision divider (res = op1 / op2), restoring, one quotient bit per clock.
// Special operands resolve in 3 cycles, normal operands in 32, plus one cycle per subnormal normalisation shift.
module ieee754_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        ready,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic [31:0] res,
   output logic        done
);

   localparam int QBITS = 27;

   typedef enum logic [3:0] {
      ST_IDLE, ST_UNPACK, ST_SPECIAL, ST_NORM1, ST_NORM2,
      ST_DIV, ST_POST, ST_ROUND, ST_PACK, ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  e1_q, e1_d, e2_q, e2_d, esp_q, esp_d;
   logic [24:0]        mant1_q, mant1_d, mant2_q, mant2_d, rem_q, rem_d;
   logic [QBITS-1:0]   q_q, q_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [22:0]        frac_q, frac_d;
   logic               guard_q, guard_d, sticky_q, sticky_d;
   logic [31:0]        res_q, res_d;

   logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, is_special;
   logic rem_ge;
   logic [24:0] rem_sub;
   logic [23:0] frac_inc;

   assign a_nan      = (&a_q[30:23]) && (|a_q[22:0]);
   assign a_inf      = (&a_q[30:23]) && !(|a_q[22:0]);
   assign a_zero     = !(|a_q[30:0]);
   assign b_nan      = (&b_q[30:23]) && (|b_q[22:0]);
   assign b_inf      = (&b_q[30:23]) && !(|b_q[22:0]);
   assign b_zero     = !(|b_q[30:0]);
   assign is_special = a_nan | a_inf | a_zero | b_nan | b_inf | b_zero;

   assign rem_ge   = (rem_q >= mant2_q);
   assign rem_sub  = rem_q - mant2_q;
   assign frac_inc = {1'b0, frac_q} + 24'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
         e1_q     <= '0;
         e2_q     <= '0;
         esp_q    <= '0;
         mant1_q  <= '0;
         mant2_q  <= '0;
         rem_q    <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         frac_q   <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
         e1_q     <= e1_d;
         e2_q     <= e2_d;
         esp_q    <= esp_d;
         mant1_q  <= mant1_d;
         mant2_q  <= mant2_d;
         rem_q    <= rem_d;
         q_q      <= q_d;
         cnt_q    <= cnt_d;
         frac_q   <= frac_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         res_q    <= res_d;
      end
   end

   // A NORM state exits on the same cycle as its final shift, so each leading zero costs exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (ready) state_d = ST_UNPACK;
         ST_UNPACK: begin
            if (is_special)               state_d = ST_SPECIAL;
            else if (a_q[30:23] == 8'd0)  state_d = ST_NORM1;
            else if (b_q[30:23] == 8'd0)  state_d = ST_NORM2;
            else                          state_d = ST_DIV;
         end
         ST_SPECIAL: state_d = ST_DONE;
         ST_NORM1:   if (mant1_q[22]) state_d = (b_q[30:23] == 8'd0) ? ST_NORM2 : ST_DIV;
         ST_NORM2:   if (mant2_q[22]) state_d = ST_DIV;
         ST_DIV:     if (cnt_q == 5'd0) state_d = ST_POST;
         ST_POST:    state_d = ST_ROUND;
         ST_ROUND:   state_d = ST_PACK;
         ST_PACK:    state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      e1_d     = e1_q;
      e2_d     = e2_q;
      esp_d    = esp_q;
      mant1_d  = mant1_q;
      mant2_d  = mant2_q;
      rem_d    = rem_q;
      q_d      = q_q;
      cnt_d    = cnt_q;
      frac_d   = frac_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      res_d    = res_q;
      case (state_q)
         ST_IDLE: begin
            if (ready) begin
               a_d = op1;
               b_d = op2;
            end
         end
         ST_UNPACK: begin
            sign_d  = a_q[31] ^ b_q[31];
            e1_d    = (a_q[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, a_q[30:23]});
            e2_d    = (b_q[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, b_q[30:23]});
            mant1_d = {1'b0, (a_q[30:23] != 8'd0), a_q[22:0]};
            mant2_d = {1'b0, (b_q[30:23] != 8'd0), b_q[22:0]};
         end
         ST_SPECIAL: begin
            if (a_nan)                                    res_d = a_q | 32'h0040_0000;
            else if (b_nan)                               res_d = b_q | 32'h0040_0000;
            else if ((a_zero && b_zero) || (a_inf && b_inf)) res_d = 32'h7FC0_0000;
            else if (b_zero || a_inf)                     res_d = {sign_q, 8'hFF, 23'd0};
            else                                          res_d = {sign_q, 31'd0};
         end
         ST_NORM1: begin
            mant1_d = {mant1_q[23:0], 1'b0};
            e1_d    = e1_q - 10'sd1;
         end
         ST_NORM2: begin
            mant2_d = {mant2_q[23:0], 1'b0};
            e2_d    = e2_q - 10'sd1;
         end
         ST_DIV: begin
            // Partial remainder stays below mant2 after a step, so bit 24 is never lost by the shift.
            q_d   = {q_q[QBITS-2:0], rem_ge};
            rem_d = rem_ge ? {rem_sub[23:0], 1'b0} : {rem_q[23:0], 1'b0};
            cnt_d = cnt_q - 5'd1;
         end
         ST_POST: begin
            if (q_q[26]) begin
               frac_d   = q_q[25:3];
               guard_d  = q_q[2];
               sticky_d = (|q_q[1:0]) | (|rem_q);
            end else begin
               frac_d   = q_q[24:2];
               guard_d  = q_q[1];
               sticky_d = q_q[0] | (|rem_q);
               esp_d    = esp_q - 10'sd1;
            end
         end
         ST_ROUND: begin
            if (guard_q && (sticky_q || frac_q[0])) begin
               frac_d = frac_inc[22:0];
               if (frac_inc[23]) esp_d = esp_q + 10'sd1;
            end
         end
         ST_PACK: begin
            if (esp_q >= 10'sd255)    res_d = {sign_q, 8'hFF, 23'd0};
            else if (esp_q <= 10'sd0) res_d = {sign_q, 31'd0};
            else                      res_d = {sign_q, esp_q[7:0], frac_q};
         end
         default: ;
      endcase
      if (state_d == ST_DIV && state_q != ST_DIV) begin
         esp_d = e1_d - e2_d + 10'sd127;
         rem_d = mant1_d;
         q_d   = '0;
         cnt_d = 5'(QBITS - 1);
      end
   end

   always_comb begin
      done = (state_q == ST_DONE);
      res  = res_q;
   end

endmodule

// File: tb/tb_ieee754_divider.sv
// Directed bench for ieee754_divider: results, latencies, special cases, range limits, reset abort, back-to-back.
module tb_ieee754_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [31:0] res;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   ieee754_divider dut (
      .clk   (clk),
      .rst   (rst),
      .ready (ready),
      .op1   (op1),
      .op2   (op2),
      .res   (res),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Latency counts the capture edge as 1 and the edge that raises done as the last.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat, output logic done_after);
      @(negedge clk);
      op1   = a;
      op2   = b;
      ready = 1'b1;
      @(posedge clk);
      lat = 1;
      #1;
      ready = 1'b0;
      op1   = 32'hDEAD_BEEF;
      op2   = 32'h1234_5678;
      r     = 32'hxxxx_xxxx;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) begin
            r = res;
            break;
         end
      end
      @(posedge clk);
      #1;
      done_after = done;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (res !== 32'h0) begin n_bad++; $display("FAIL reset_res got %h want %h", res, 32'h0); end
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [31:0] r; int lat; logic da;
      do_op(32'h40C0_0000, 32'h4000_0000, r, lat, da);
      n_cmp++;
      if (r !== 32'h4040_0000) begin n_bad++; $display("FAIL basic_res got %h want %h", r, 32'h4040_0000); end
      n_cmp++;
      if (lat !== 32) begin n_bad++; $display("FAIL basic_latency got %0d want 32", lat); end
      n_cmp++;
      if (da !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", da); end
   endtask

   task automatic test_rounding;
      logic [31:0] r; int lat; logic da;
      do_op(32'h3F80_0000, 32'h4040_0000, r, lat, da);
      n_cmp++;
      if (r !== 32'h3EAA_AAAB) begin n_bad++; $display("FAIL round_third got %h want %h", r, 32'h3EAA_AAAB); end
      do_op(32'h3F80_0000, 32'h3F80_0000, r, lat, da);
      n_cmp++;
      if (r !== 32'h3F80_0000) begin n_bad++; $display("FAIL round_one got %h want %h", r, 32'h3F80_0000); end
      n_cmp++;
      if (lat !== 32) begin n_bad++; $display("FAIL round_one_latency got %0d want 32", lat); end
   endtask

   task automatic test_special;
      logic [31:0] va[5] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7FA0_0000};
      logic [31:0] vb[5] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h3F80_0000};
      logic [31:0] ve[5] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FE0_0000};
      logic [31:0] r; int lat; logic da;
      for (int i = 0; i < 5; i++) begin
         do_op(va[i], vb[i], r, lat, da);
         n_cmp++;
         if (r !== ve[i]) begin n_bad++; $display("FAIL special_res[%0d] got %h want %h", i, r, ve[i]); end
         n_cmp++;
         if (lat !== 3) begin n_bad++; $display("FAIL special_latency[%0d] got %0d want 3", i, lat); end
      end
   endtask

   task automatic test_range;
      logic [31:0] va[3] = '{32'h7F7F_FFFF, 32'h0080_0000, 32'h8080_0000};
      logic [31:0] vb[3] = '{32'h3F00_0000, 32'h4000_0000, 32'h4000_0000};
      logic [31:0] ve[3] = '{32'h7F80_0000, 32'h0000_0000, 32'h8000_0000};
      logic [31:0] r; int lat; logic da;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], r, lat, da);
         n_cmp++;
         if (r !== ve[i]) begin n_bad++; $display("FAIL range_res[%0d] got %h want %h", i, r, ve[i]); end
      end
   endtask

   task automatic test_subnormal;
      logic [31:0] r; int lat; logic da;
      // op1 needs one normalisation shift, op2 needs two.
      do_op(32'h0040_0000, 32'h0020_0000, r, lat, da);
      n_cmp++;
      if (r !== 32'h4000_0000) begin n_bad++; $display("FAIL subnormal_res got %h want %h", r, 32'h4000_0000); end
      n_cmp++;
      if (lat !== 35) begin n_bad++; $display("FAIL subnormal_latency got %0d want 35", lat); end
   endtask

   task automatic test_reset_midop;
      logic [31:0] r; int lat; logic da; int pulses;
      @(negedge clk);
      op1   = 32'h40C0_0000;
      op2   = 32'h4000_0000;
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (res !== 32'h0) begin n_bad++; $display("FAIL midreset_res got %h want %h", res, 32'h0); end
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL midreset_done got %b want 0", done); end
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin n_bad++; $display("FAIL midreset_no_done got %0d pulses want 0", pulses); end
      do_op(32'h4080_0000, 32'h4000_0000, r, lat, da);
      n_cmp++;
      if (r !== 32'h4000_0000) begin n_bad++; $display("FAIL after_reset_res got %h want %h", r, 32'h4000_0000); end
   endtask

   task automatic test_back_to_back;
      int n; logic seen;
      @(negedge clk);
      op1   = 32'h40C0_0000;
      op2   = 32'h4000_0000;
      ready = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (done) begin seen = 1'b1; break; end
      end
      n_cmp++;
      if (seen !== 1'b1 || res !== 32'h4040_0000) begin
         n_bad++; $display("FAIL b2b_first got done=%b res=%h want done=1 res=%h", seen, res, 32'h4040_0000);
      end
      // ready stays high; the next capture takes these operands once the FSM is back in idle.
      op1 = 32'h3F80_0000;
      op2 = 32'h4040_0000;
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (done) break;
      end
      ready = 1'b0;
      n_cmp++;
      if (n !== 33) begin n_bad++; $display("FAIL b2b_gap got %0d want 33", n); end
      n_cmp++;
      if (res !== 32'h3EAA_AAAB) begin n_bad++; $display("FAIL b2b_second got %h want %h", res, 32'h3EAA_AAAB); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_special();
      test_range();
      test_subnormal();
      test_reset_midop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
